// File: rtl/yu_fetch_sequencer_pkg.sv
// yu_fetch_pkg: shared FSM state, next-PC select encoding and PC step for the Yu fetch sequencer.
package yu_fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;
  typedef enum logic [1:0] {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_TRAP} pc_sel_t;
  localparam int PC_STEP = 4;
endpackage

// File: rtl/yu_fetch_sequencer_if.sv
// yu_fetch_if: instruction-memory handshake, redirect/control inputs and PC status of the fetch sequencer.
interface yu_fetch_if #(parameter int DATA_WIDTH = 32);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic                  inst_valid;
  logic                  stall;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [DATA_WIDTH-1:0] jump_target;
  logic                  halt;
  logic                  resume;
  logic [DATA_WIDTH-1:0] pc;
  logic [31:0]           retired_count;
  logic                  trap;
  logic [DATA_WIDTH-1:0] trap_pc;
  modport master (
    input  imem_ack, stall, branch_taken, branch_target, jump, jump_target, halt, resume,
    output imem_req, imem_addr, inst_valid, pc, retired_count, trap, trap_pc
  );
  modport slave (
    output imem_ack, stall, branch_taken, branch_target, jump, jump_target, halt, resume,
    input  imem_req, imem_addr, inst_valid, pc, retired_count, trap, trap_pc
  );
endinterface

// File: rtl/yu_fetch_sequencer_next_pc_mux.sv
// yu_next_pc_mux: next-PC priority select (trap > jump > branch > pc+4) with misaligned-target detect.
// YU_PC_MISALIGN_TRAP_EN enables the trap; otherwise target bits[1:0] are cleared.
module yu_next_pc_mux
  import yu_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_target,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_jump_target,
  output logic [DATA_WIDTH-1:0] o_next_pc,
  output pc_sel_t               o_sel
);
`ifdef YU_PC_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  logic [DATA_WIDTH-1:0] w_mask, w_target;
  logic                  w_misalign;
  assign w_mask     = TRAP_EN ? '1 : ~DATA_WIDTH'(3);
  assign w_target   = (i_jump ? i_jump_target : i_branch_target) & w_mask;
  assign w_misalign = TRAP_EN && (i_jump || i_branch_taken) && |w_target[1:0];
  always_comb begin
    o_sel     = w_misalign ? SEL_TRAP : i_jump ? SEL_JUMP : i_branch_taken ? SEL_BRANCH : SEL_SEQ;
    o_next_pc = o_sel == SEL_TRAP ? TRAP_VECTOR :
                o_sel == SEL_SEQ  ? i_pc + DATA_WIDTH'(PC_STEP) : w_target;
  end
endmodule

// File: rtl/yu_fetch_sequencer.sv
// yu_fetch_sequencer: owns the PC, runs the imem req/ack handshake, stall/halt/resume and retire counting.
// Misaligned-target trap is enabled by YU_PC_MISALIGN_TRAP_EN (inside yu_next_pc_mux).
module yu_fetch_sequencer
  import yu_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input logic       clk,
  input logic       rst,
  yu_fetch_if.master bus
);
  state_t                r_state, w_next_state;
  pc_sel_t               w_sel;
  logic [DATA_WIDTH-1:0] r_pc, w_next_pc, r_trap_pc;
  logic [31:0]           r_retired;
  logic                  r_trap, w_commit;
  yu_next_pc_mux #(.DATA_WIDTH(DATA_WIDTH), .TRAP_VECTOR(TRAP_VECTOR)) u_mux (
    .i_pc           (r_pc),
    .i_branch_taken (bus.branch_taken),
    .i_branch_target(bus.branch_target),
    .i_jump         (bus.jump),
    .i_jump_target  (bus.jump_target),
    .o_next_pc      (w_next_pc),
    .o_sel          (w_sel)
  );
  assign w_commit = r_state == FETCH && bus.imem_ack && !bus.stall;
  always_ff @(posedge clk)
    r_state <= rst ? BOOT : w_next_state;
  always_comb
    w_next_state = r_state == BOOT  ? FETCH :
                   r_state == FETCH ? (w_commit && bus.halt ? HALTED : FETCH) :
                   (bus.resume ? FETCH : HALTED);
  always_comb begin
    bus.imem_req   = r_state == FETCH;
    bus.inst_valid = r_state == FETCH && bus.imem_ack;
    bus.imem_addr  = r_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_VECTOR;
      r_retired <= '0;
      r_trap    <= 1'b0;
      r_trap_pc <= '0;
    end else begin
      r_trap <= w_commit && w_sel == SEL_TRAP;
      if (w_commit) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
      if (w_commit && w_sel == SEL_TRAP) r_trap_pc <= r_pc;
    end
  end
  assign bus.pc            = r_pc;
  assign bus.retired_count = r_retired;
  assign bus.trap          = r_trap;
  assign bus.trap_pc       = r_trap_pc;
endmodule
